// File: rtl/i2c_reg_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i2c_regs_pkg
// Brief    : Shared types and constants for the I2C register bank.
// Revision : 1.0
// ============================================================================
package i2c_regs_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PTR   = 2'd1,
        S_WRITE = 2'd2,
        S_READ  = 2'd3
    } state_t;

    localparam logic [7:0] c_filler_byte = 8'hFF;
    localparam logic [7:0] c_id_default  = 8'h5C;

endpackage
`default_nettype wire

// File: rtl/i2c_reg_bank_if.sv
`default_nettype none
// ============================================================================
// Module   : i2c_reg_bank_if
// Brief    : Byte-stream handshake between the I2C slave core and the bank.
// Revision : 1.0
// ============================================================================
interface i2c_reg_bank_if;

    logic       bus_start;
    logic       bus_stop;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       tx_req;
    logic       tx_ack;
    logic [7:0] tx_data;

    modport master (
        output bus_start, bus_stop, rx_valid, rx_data, tx_req,
        input  tx_ack, tx_data
    );

    modport slave (
        input  bus_start, bus_stop, rx_valid, rx_data, tx_req,
        output tx_ack, tx_data
    );

endinterface
`default_nettype wire

// File: rtl/i2c_reg_bank.sv
`default_nettype none
// ============================================================================
// Module   : i2c_reg_bank
// Brief    : Pointer-addressed register file fed by the I2C slave byte stream.
// Revision : 1.0
// ============================================================================
module i2c_reg_bank
    import i2c_regs_pkg::*;
#(
    parameter int         NREGS    = 16,
    parameter logic [7:0] ID_VALUE = c_id_default,
    localparam int        AW       = $clog2(NREGS)
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    i2c_reg_bank_if.slave             bus,
    output      logic [NREGS*8-1:0]   regs_flat,
    output      logic                 wr_strobe,
    output      logic [AW-1:0]        wr_addr
);

    localparam logic [AW-1:0] c_id_idx = AW'(NREGS - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_ptr;
    logic [AW-1:0] w_ptr_nxt;
    logic          r_tx_ack;
    logic [7:0]    r_tx_data;
    logic [7:0]    w_tx_data_nxt;
    logic          r_wr_strobe;
    logic [AW-1:0] r_wr_addr;
    logic          w_do_write;
    logic          w_wr_en;
    logic [7:0]    w_regs [NREGS];
    logic [7:0]    w_rd_byte;

    // Top index is a constant ID; every other index is a plain 8-bit register.
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
        if (gi == NREGS - 1) begin : g_id
            assign w_regs[gi] = ID_VALUE;
        end else begin : g_rw
            logic [7:0] r_val;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_val <= '0;
                end else if (w_wr_en && (r_ptr == AW'(gi))) begin
                    r_val <= bus.rx_data;
                end
            end
            assign w_regs[gi] = r_val;
        end
        assign regs_flat[gi*8 +: 8] = w_regs[gi];
    end

    assign w_rd_byte = w_regs[r_ptr];
    assign w_wr_en   = w_do_write && (r_ptr != c_id_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Data event is resolved in the current state first; bus events then pick the next state.
    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_tx_data_nxt = r_tx_data;
        w_do_write    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.tx_req) w_tx_data_nxt = c_filler_byte;
            end
            S_PTR: begin
                if (bus.rx_valid) begin
                    w_ptr_nxt   = bus.rx_data[AW-1:0];
                    w_state_nxt = S_WRITE;
                    if (bus.tx_req) w_tx_data_nxt = c_filler_byte;
                end else if (bus.tx_req) begin
                    w_tx_data_nxt = w_rd_byte;
                    w_ptr_nxt     = r_ptr + AW'(1);
                    w_state_nxt   = S_READ;
                end
            end
            S_WRITE: begin
                if (bus.rx_valid) begin
                    w_do_write = 1'b1;
                    w_ptr_nxt  = r_ptr + AW'(1);
                    if (bus.tx_req) w_tx_data_nxt = c_filler_byte;
                end else if (bus.tx_req) begin
                    w_tx_data_nxt = w_rd_byte;
                    w_ptr_nxt     = r_ptr + AW'(1);
                    w_state_nxt   = S_READ;
                end
            end
            S_READ: begin
                if (bus.tx_req) begin
                    if (bus.rx_valid) begin
                        w_tx_data_nxt = c_filler_byte;
                    end else begin
                        w_tx_data_nxt = w_rd_byte;
                        w_ptr_nxt     = r_ptr + AW'(1);
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (bus.bus_stop) begin
            w_state_nxt = S_IDLE;
        end else if (bus.bus_start) begin
            w_state_nxt = S_PTR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= '0;
            r_tx_ack    <= 1'b0;
            r_tx_data   <= c_filler_byte;
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= '0;
        end else begin
            r_ptr       <= w_ptr_nxt;
            r_tx_ack    <= bus.tx_req;
            r_tx_data   <= w_tx_data_nxt;
            r_wr_strobe <= w_wr_en;
            if (w_wr_en) r_wr_addr <= r_ptr;
        end
    end

    assign bus.tx_ack  = r_tx_ack;
    assign bus.tx_data = r_tx_data;
    assign wr_strobe   = r_wr_strobe;
    assign wr_addr     = r_wr_addr;

endmodule
`default_nettype wire

// File: tb/tb_i2c_reg_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_reg_bank
// Brief    : Directed self-checking bench for i2c_reg_bank.
// Revision : 1.0
// ============================================================================
module tb_i2c_reg_bank;

    localparam int NREGS = 16;
    localparam int AW    = 4;

    logic               clk;
    logic               rst_n;
    logic [NREGS*8-1:0] regs_flat;
    logic               wr_strobe;
    logic [AW-1:0]      wr_addr;

    int n_vec;
    int n_miss;
    int strobe_cnt;

    i2c_reg_bank_if bus();

    i2c_reg_bank #(.NREGS(NREGS), .ID_VALUE(8'h5C)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .regs_flat (regs_flat),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (wr_strobe) strobe_cnt++;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] reg_at(input int i);
        return regs_flat[i*8 +: 8];
    endfunction

    task automatic start_pulse();
        @(negedge clk); bus.bus_start = 1'b1;
        @(negedge clk); bus.bus_start = 1'b0;
    endtask

    task automatic stop_pulse();
        @(negedge clk); bus.bus_stop = 1'b1;
        @(negedge clk); bus.bus_stop = 1'b0;
    endtask

    task automatic rx_byte(input string tag, input logic [7:0] b, input logic exp_stb, input logic [3:0] exp_addr);
        @(negedge clk); bus.rx_valid = 1'b1; bus.rx_data = b;
        @(negedge clk); bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
        check_eq({tag, ".stb"}, wr_strobe, exp_stb);
        if (exp_stb) check_eq({tag, ".addr"}, wr_addr, exp_addr);
    endtask

    task automatic tx_read(input string tag, input logic [7:0] exp);
        @(negedge clk); bus.tx_req = 1'b1;
        @(negedge clk); bus.tx_req = 1'b0;
        check_eq({tag, ".ack"}, bus.tx_ack, 1'b1);
        check_eq({tag, ".data"}, bus.tx_data, exp);
    endtask

    initial begin
        int s0;
        n_vec = 0; n_miss = 0; strobe_cnt = 0;
        rst_n = 1'b0;
        bus.bus_start = 1'b0; bus.bus_stop = 1'b0;
        bus.rx_valid = 1'b0; bus.rx_data = 8'h00; bus.tx_req = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        check_eq("rst.ack", bus.tx_ack, 1'b0);
        check_eq("rst.txd", bus.tx_data, 8'hFF);
        check_eq("rst.stb", wr_strobe, 1'b0);
        check_eq("rst.addr", wr_addr, 4'd0);
        check_eq("rst.regs", regs_flat, {8'h5C, 120'h0});
        rst_n = 1'b1;
        tx_read("idle_rd", 8'hFF);
        @(negedge clk);
        check_eq("idle_rd.ack_drop", bus.tx_ack, 1'b0);

        // Write burst
        s0 = strobe_cnt;
        start_pulse();
        rx_byte("wb.ptr", 8'h03, 1'b0, 4'd0);
        rx_byte("wb.d0", 8'hCC, 1'b1, 4'd3);
        rx_byte("wb.d1", 8'hDD, 1'b1, 4'd4);
        stop_pulse();
        check_eq("wb.reg3", reg_at(3), 8'hCC);
        check_eq("wb.reg4", reg_at(4), 8'hDD);
        check_eq("wb.nstb", strobe_cnt - s0, 2);

        // Pointer then repeated-START read
        start_pulse();
        rx_byte("rs.ptr", 8'h03, 1'b0, 4'd0);
        start_pulse();
        tx_read("rs.r0", 8'hCC);
        tx_read("rs.r1", 8'hDD);
        tx_read("rs.r2", 8'h00);
        tx_read("rs.r3", 8'h00);
        stop_pulse();

        // Wrap and read-only register
        s0 = strobe_cnt;
        start_pulse();
        rx_byte("wr.ptr", 8'h0E, 1'b0, 4'd0);
        rx_byte("wr.d14", 8'h11, 1'b1, 4'd14);
        rx_byte("wr.d15", 8'h22, 1'b0, 4'd0);
        rx_byte("wr.d0", 8'h33, 1'b1, 4'd0);
        stop_pulse();
        check_eq("wr.reg14", reg_at(14), 8'h11);
        check_eq("wr.reg15", reg_at(15), 8'h5C);
        check_eq("wr.reg0", reg_at(0), 8'h33);
        check_eq("wr.nstb", strobe_cnt - s0, 2);

        // Pointer persistence across STOP, wrap on read
        start_pulse();
        rx_byte("pp.ptr", 8'h1F, 1'b0, 4'd0);
        stop_pulse();
        start_pulse();
        tx_read("pp.r15", 8'h5C);
        tx_read("pp.r0", 8'h33);
        stop_pulse();

        // Back-to-back writes, then back-to-back reads
        start_pulse();
        rx_byte("bb.ptr", 8'h08, 1'b0, 4'd0);
        @(negedge clk); bus.rx_valid = 1'b1; bus.rx_data = 8'hA1;
        @(negedge clk); bus.rx_data = 8'hA2;
        check_eq("bb.stb0", wr_strobe, 1'b1);
        check_eq("bb.addr0", wr_addr, 4'd8);
        @(negedge clk); bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
        check_eq("bb.stb1", wr_strobe, 1'b1);
        check_eq("bb.addr1", wr_addr, 4'd9);
        start_pulse();
        rx_byte("bb.ptr2", 8'h08, 1'b0, 4'd0);
        start_pulse();
        @(negedge clk); bus.tx_req = 1'b1;
        @(negedge clk);
        check_eq("bb.rd0", bus.tx_data, 8'hA1);
        @(negedge clk); bus.tx_req = 1'b0;
        check_eq("bb.rd1", bus.tx_data, 8'hA2);
        check_eq("bb.ack1", bus.tx_ack, 1'b1);

        // rx_valid together with tx_req in WRITE, then rx_valid with STOP
        start_pulse();
        rx_byte("sim.ptr", 8'h0A, 1'b0, 4'd0);
        @(negedge clk); bus.rx_valid = 1'b1; bus.rx_data = 8'h5A; bus.tx_req = 1'b1;
        @(negedge clk); bus.rx_valid = 1'b0; bus.tx_req = 1'b0;
        check_eq("sim.stb", wr_strobe, 1'b1);
        check_eq("sim.addr", wr_addr, 4'd10);
        check_eq("sim.ack", bus.tx_ack, 1'b1);
        check_eq("sim.txd", bus.tx_data, 8'hFF);
        check_eq("sim.reg10", reg_at(10), 8'h5A);
        @(negedge clk); bus.rx_valid = 1'b1; bus.rx_data = 8'h6B; bus.bus_stop = 1'b1;
        @(negedge clk); bus.rx_valid = 1'b0; bus.bus_stop = 1'b0;
        check_eq("sim.stop_stb", wr_strobe, 1'b1);
        check_eq("sim.reg11", reg_at(11), 8'h6B);
        tx_read("sim.idle_rd", 8'hFF);
        rx_byte("sim.idle_rx", 8'h77, 1'b0, 4'd0);
        check_eq("sim.reg12", reg_at(12), 8'h00);

        // Reset mid-burst
        start_pulse();
        rx_byte("mr.ptr", 8'h03, 1'b0, 4'd0);
        @(negedge clk); rst_n = 1'b0;
        #1;
        check_eq("mr.regs", regs_flat, {8'h5C, 120'h0});
        check_eq("mr.txd", bus.tx_data, 8'hFF);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        start_pulse();
        tx_read("mr.rd", 8'h00);
        tx_read("mr.rd1", 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/i2c_reg_bank.md
# i2c_reg_bank

Byte-level register bank that sits directly downstream of the `i2c` slave core and turns its received byte stream into a pointer-addressed register file for the display logic. The first data byte after each (repeated) START is the register pointer. Later written bytes store at the pointer with auto-increment. Read transfers return bytes from the current pointer, also with auto-increment. The register contents are exported flat to the rotating-display controller, together with a per-write update strobe.

## Interface
- `NREGS`, 16: number of 8-bit registers; power of two, 2..256.
- `AW`, $clog2(NREGS): pointer width; derived, do not override.
- `ID_VALUE`, 8'h5C: constant returned by the read-only register at index NREGS-1.

- `clk` in 1: single clock for the block.
- `rst_n` in 1: reset; asynchronous assert, active-low.
- `bus_start` in 1: one-cycle pulse on START or repeated START. Generated by the slave core and already synchronous to `clk`.
- `bus_stop` in 1: one-cycle pulse on STOP.
- `rx_valid` in 1: one-cycle pulse when a master-written data byte has been ACKed. Address bytes never produce this pulse.
- `rx_data` in 8: received byte; valid only while `rx_valid` is high.
- `tx_req` in 1: one-cycle pulse when the core needs the next byte to shift out.
- `tx_ack` out 1: one-cycle pulse answering `tx_req`.
- `tx_data` out 8: byte to transmit; valid from `tx_ack` onward and held until the next `tx_ack`.
- `regs_flat` out NREGS*8: register i occupies bits [8i+7:8i].
- `wr_strobe` out 1: one-cycle pulse when a register value has changed.
- `wr_addr` out AW: index of the register just written; valid with `wr_strobe`.

## Operation
- **Reset:**
  - Outputs: `tx_ack`=0, `tx_data`=8'hFF, `wr_strobe`=0, `wr_addr`=0.
  - Registers: all writable registers 0x00. Register NREGS-1 reads `ID_VALUE` at all times.
  - Internal: pointer=0, state IDLE.
- **States:**
  - **IDLE**
    - `bus_start` → PTR.
    - `rx_valid` is ignored.
    - `tx_req` is answered with 8'hFF; pointer unchanged.
  - **PTR**
    - `rx_valid`: pointer ← `rx_data[AW-1:0]` (upper bits discarded) → WRITE. No register write.
    - `tx_req`: serve a read (see below) → READ.
  - **WRITE**
    - `rx_valid`: reg[pointer] ← `rx_data`; pointer ← pointer+1.
    - `tx_req`: serve a read → READ.
  - **READ**
    - `tx_req`: serve a read.
    - `rx_valid`: ignored.
  - **All non-IDLE states**
    - `bus_start` → PTR.
    - `bus_stop` → IDLE.
- **Serving a read:** `tx_data` ← reg[pointer]; pointer ← pointer+1.
- **Pointer handling:**
  - The pointer persists across transactions and across STOP. A write of the pointer alone followed by a repeated-START read returns data from that pointer.
  - Wrap-around: pointer NREGS-1 + 1 → 0, in both write and read.
- **Read-only register (index NREGS-1):**
  - A write to it leaves its value unchanged and produces no `wr_strobe`.
  - The pointer still increments.
- **Simultaneous events:**
  - A data event (`rx_valid`/`tx_req`) in the same cycle as `bus_start`/`bus_stop` is processed in the current state first. The bus event then sets the next state.
  - `rx_valid` and `tx_req` together is a protocol error:
    - `rx_valid` is processed.
    - `tx_req` is acked with 8'hFF.
    - The pointer advances once.
  - `bus_start` and `bus_stop` together: `bus_stop` wins → IDLE.
- **Reset mid-transfer:** everything returns to reset values immediately. Bytes in flight are lost.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- `rx_valid` in cycle N:
  - `regs_flat` shows the new value in cycle N+1.
  - `wr_strobe` and `wr_addr` are high in cycle N+1 for one cycle.
- `tx_req` in cycle N: `tx_ack` and `tx_data` are valid in cycle N+1.
- Back-to-back `rx_valid` or `tx_req` on every cycle is supported at full rate.
- Read-after-write: a `tx_req` one cycle after `rx_valid` to the same register returns the new value.

## Structure
- Package `i2c_regs_pkg` holds:
  - the state enumeration (IDLE, PTR, WRITE, READ);
  - the 8'hFF filler constant;
  - the default `ID_VALUE`.
- No sub-module. The register array, read mux and FSM live in one module of roughly 150–250 lines.

## Test plan
- **Reset values:** reset, then `tx_req` in IDLE → `tx_ack` with 8'hFF; `regs_flat` all 0 except top byte 0x5C.
- **Write burst:** `bus_start`, rx 0x03, rx 0xCC, rx 0xDD, `bus_stop`:
  - reg3=0xCC, reg4=0xDD;
  - `wr_strobe` pulses exactly twice, with `wr_addr` 3 then 4.
- **Pointer then repeated-START read:** `bus_start`, rx 0x03, `bus_start`, 4× `tx_req` → `tx_data` 0xCC, 0xDD, 0x00, 0x00, each valid one cycle after its request.
- **Wrap and read-only register:** `bus_start`, rx 0x0E, rx 0x11, rx 0x22, rx 0x33 → reg14=0x11, reg15 stays 0x5C (no strobe), reg0=0x33.
- **Pointer persistence and wrap on read:** after the wrap test, `bus_stop`, then `bus_start` and 2× `tx_req` → 0x5C then 0x33 (pointer was 0x0F from the pointer-only sequence `bus_start`, rx 0x0F, `bus_stop`).
- **Reset mid-burst:** drop `rst_n` after the pointer byte → all registers 0 and pointer 0. A following `bus_start` plus 1× `tx_req` returns 0x00.
